// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60), coordinate type and sync payload used by the
// timing generator and the sprite renderers.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Undelayed sync/blank bundle carried through the renderer-matching delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bits_t;

  // Half-open window test lo <= c < hi, done at 32 bits so hi may equal 1024
  function automatic logic in_window(input coord_t c, input int unsigned lo,
                                     input int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Async-reset shift register used to re-time sync/blank to the renderer latency.
// DEPTH = 0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int unsigned        WIDTH     = 1,
  parameter int unsigned        DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing source: scan counters, blank, frame tick and renderer-aligned hsync/vsync/blank.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   frame_tick,
  output logic   hs_dly,
  output logic   vs_dly,
  output logic   blank_dly
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam coord_t      H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam coord_t      V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam sync_bits_t  SYNC_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank: 1'b0};

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end

  logic       run_q;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       tick_q, tick_d;
  sync_bits_t sync_q, sync_d;
  sync_bits_t sync_dly;

  // Next scan position; the first cycle after reset re-presents (0,0) before counting
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (run_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        y_d = y_q;
      end
    end
  end

  // Sync/blank/tick derived from the next position so they land with the counters
  always_comb begin
    sync_d       = SYNC_RST;
    sync_d.blank = (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
    sync_d.hs    = in_window(x_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    sync_d.vs    = in_window(y_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    tick_d       = (x_d == '0) && (32'(y_d) == V_VISIBLE);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
      sync_q <= SYNC_RST;
    end else begin
      run_q  <= 1'b1;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
      sync_q <= sync_d;
    end
  end

  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_RST)
  ) u_sync_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (sync_q),
    .q_o    (sync_dly)
  );

  assign DrawX      = x_q;
  assign DrawY      = y_q;
  assign blank      = sync_q.blank;
  assign frame_tick = tick_q;
  assign hs_dly     = sync_dly.hs;
  assign vs_dly     = sync_dly.vs;
  assign blank_dly  = sync_dly.blank;

endmodule
